// File: rtl/phy_scan_rst_ctrl_if.sv
// Reset-control bundle for phy_scan_rst_ctrl: scan controls, functional resets in, muxed resets out.
// Latency: n/a (signal bundle only).
// Backpressure: none; all signals are level-sensitive resets and mode controls.
interface phy_scan_rst_ctrl_if #(
    parameter int NUM_CH = 4
);
    logic              scan_mode_en_in;
    logic              scan_rst_n_in;
    logic [NUM_CH-1:0] fcn_rst_n_in;
    logic [NUM_CH-1:0] fcn_rst_n_out;
    logic              mode_sel_out;
    logic              busy_out;

    // Reset source side (tester / functional reset generators)
    modport master (
        output scan_mode_en_in,
        output scan_rst_n_in,
        output fcn_rst_n_in,
        input  fcn_rst_n_out,
        input  mode_sel_out,
        input  busy_out
    );

    // Reset controller side
    modport slave (
        input  scan_mode_en_in,
        input  scan_rst_n_in,
        input  fcn_rst_n_in,
        output fcn_rst_n_out,
        output mode_sel_out,
        output busy_out
    );
endinterface

// File: rtl/phy_scan_rst_ctrl.sv
// Per-channel reset synchroniser plus scan-reset mux, with a forced-reset drain window on mode changes.
// Latency: reset assert is immediate; release after SYNC_STAGES edges; scan entry SYNC_STAGES+1+HOLD_CYCLES edges.
// Backpressure: none; outputs follow inputs/state every cycle, scan reset passes through combinationally in SCAN.
module phy_scan_rst_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    phy_scan_rst_ctrl_if.slave  rst_if
);

    localparam int               CNT_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_FCN           = 2'd0,
        ST_DRAIN_TO_SCAN = 2'd1,
        ST_SCAN          = 2'd2,
        ST_DRAIN_TO_FCN  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0]   mode_sync_q;
    logic                     mode_sync;
    logic [NUM_CH-1:0]        fcn_sync;
    logic                     mode_sel_q, mode_sel_d;
    logic                     busy_q, busy_d;
    logic [NUM_CH-1:0]        fcn_rst_n_mux;

    // Bring the asynchronous scan-mode enable into the clk_in domain
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mode_sync_q <= '0;
        end else begin
            mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], rst_if.scan_mode_en_in};
        end
    end

    assign mode_sync = mode_sync_q[SYNC_STAGES-1];

    // One release synchroniser per channel: async assert, sync deassert.
    // Held clear while draining back to functional mode so every channel
    // releases together a full synchroniser delay after FCN is re-entered.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic                   ch_arst_n;
        logic [SYNC_STAGES-1:0] ch_sync_q;

        assign ch_arst_n = rst_n_in & rst_if.fcn_rst_n_in[gi];

        // Shift ones in once the channel's reset source is released
        always_ff @(posedge clk_in or negedge ch_arst_n) begin
            if (!ch_arst_n) begin
                ch_sync_q <= '0;
            end else if (state_q == ST_DRAIN_TO_FCN) begin
                ch_sync_q <= '0;
            end else begin
                ch_sync_q <= {ch_sync_q[SYNC_STAGES-2:0], 1'b1};
            end
        end

        assign fcn_sync[gi] = ch_sync_q[SYNC_STAGES-1];
    end

    // State, drain counter and registered status flags
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_FCN;
            cnt_q      <= '0;
            mode_sel_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_sel_q <= mode_sel_d;
            busy_q     <= busy_d;
        end
    end

    // Mode sequencing; a mode flip during a drain restarts the window toward the new mode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_FCN: begin
                if (mode_sync) begin
                    state_d = ST_DRAIN_TO_SCAN;
                    cnt_d   = CNT_RELOAD;
                end
            end
            ST_DRAIN_TO_SCAN: begin
                if (!mode_sync) begin
                    state_d = ST_DRAIN_TO_FCN;
                    cnt_d   = CNT_RELOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_SCAN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SCAN: begin
                if (!mode_sync) begin
                    state_d = ST_DRAIN_TO_FCN;
                    cnt_d   = CNT_RELOAD;
                end
            end
            ST_DRAIN_TO_FCN: begin
                if (mode_sync) begin
                    state_d = ST_DRAIN_TO_SCAN;
                    cnt_d   = CNT_RELOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_FCN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_FCN;
                cnt_d   = '0;
            end
        endcase
        mode_sel_d = (state_d == ST_SCAN);
        busy_d     = (state_d == ST_DRAIN_TO_SCAN) || (state_d == ST_DRAIN_TO_FCN);
    end

    // Output mux selected only by registered state so mode changes cannot glitch a channel
    always_comb begin
        fcn_rst_n_mux = '0;
        unique case (state_q)
            ST_FCN:  fcn_rst_n_mux = fcn_sync;
            ST_SCAN: fcn_rst_n_mux = {NUM_CH{rst_if.scan_rst_n_in}};
            default: fcn_rst_n_mux = '0;
        endcase
    end

    assign rst_if.fcn_rst_n_out = fcn_rst_n_mux;
    assign rst_if.mode_sel_out  = mode_sel_q;
    assign rst_if.busy_out      = busy_q;

endmodule

// File: tb/tb_phy_scan_rst_ctrl.sv
// Scoreboard bench for phy_scan_rst_ctrl: directed mode/reset scenarios followed by random traffic.
// Expected outputs come from a mode/drain reference model and are queued; a monitor compares every half cycle.
// Stimulus changes on the falling edge; checks land 2 time units after each clock edge.
module tb_phy_scan_rst_ctrl;

    localparam int NUM_CH = 4;
    localparam int SS     = 2;
    localparam int HOLD   = 8;

    typedef struct {
        logic [NUM_CH-1:0] rst_out;
        logic              msel;
        logic              busy;
    } exp_t;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;

    always #5 clk_in = ~clk_in;

    phy_scan_rst_ctrl_if #(.NUM_CH(NUM_CH)) rst_if ();

    phy_scan_rst_ctrl #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SS),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rst_if   (rst_if)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: what the block has settled on, whether a drain is running,
    // which mode that drain heads for, and how many edges of it remain.
    logic m_hist [SS];
    logic m_settled_scan;
    logic m_in_drain;
    logic m_target_scan;
    int   m_remaining;
    int   m_ok_edges [NUM_CH];

    task automatic model_async();
        if (!rst_n_in) begin
            m_settled_scan = 1'b0;
            m_in_drain     = 1'b0;
            m_target_scan  = 1'b0;
            m_remaining    = 0;
            for (int k = 0; k < SS; k++) m_hist[k] = 1'b0;
            for (int i = 0; i < NUM_CH; i++) m_ok_edges[i] = 0;
        end
        for (int i = 0; i < NUM_CH; i++)
            if (!rst_if.fcn_rst_n_in[i]) m_ok_edges[i] = 0;
    endtask

    task automatic model_edge();
        logic want_scan;
        logic clearing;
        if (!rst_n_in) begin
            model_async();
            return;
        end
        want_scan = m_hist[SS-1];
        clearing  = m_in_drain && !m_target_scan;
        if (!m_in_drain) begin
            if (want_scan != m_settled_scan) begin
                m_in_drain    = 1'b1;
                m_target_scan = want_scan;
                m_remaining   = HOLD;
            end
        end else if (want_scan != m_target_scan) begin
            m_target_scan = want_scan;
            m_remaining   = HOLD;
        end else begin
            m_remaining--;
            if (m_remaining == 0) begin
                m_in_drain     = 1'b0;
                m_settled_scan = m_target_scan;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (clearing || !rst_if.fcn_rst_n_in[i]) m_ok_edges[i] = 0;
            else if (m_ok_edges[i] < SS)             m_ok_edges[i]++;
        end
        for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = rst_if.scan_mode_en_in;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.rst_out = '0;
        e.msel    = 1'b0;
        e.busy    = 1'b0;
        if (rst_n_in) begin
            if (m_in_drain) begin
                e.busy = 1'b1;
            end else if (m_settled_scan) begin
                e.msel    = 1'b1;
                e.rst_out = {NUM_CH{rst_if.scan_rst_n_in}};
            end else begin
                for (int i = 0; i < NUM_CH; i++) e.rst_out[i] = (m_ok_edges[i] >= SS);
            end
        end
        return e;
    endfunction

    // Drive at the falling edge (checking the asynchronous effect), then advance the model on the rising edge
    task automatic step(input logic rst, input logic mode, input logic srst, input logic [NUM_CH-1:0] fcn);
        @(negedge clk_in);
        rst_n_in               = rst;
        rst_if.scan_mode_en_in = mode;
        rst_if.scan_rst_n_in   = srst;
        rst_if.fcn_rst_n_in    = fcn;
        #1;
        model_async();
        exp_q.push_back(model_out());
        @(posedge clk_in);
        #1;
        model_edge();
        exp_q.push_back(model_out());
    endtask

    task automatic repeat_step(input int n, input logic rst, input logic mode, input logic srst,
                               input logic [NUM_CH-1:0] fcn);
        for (int n_i = 0; n_i < n; n_i++) step(rst, mode, srst, fcn);
    endtask

    // Monitor: compare the DUT against every queued expectation shortly after each clock edge
    initial begin
        exp_t e;
        forever begin
            @(clk_in);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (rst_if.fcn_rst_n_out !== e.rst_out) begin
                    errors++;
                    $display("FAIL fcn_rst_n_out t=%0t got %h expected %h", $time, rst_if.fcn_rst_n_out, e.rst_out);
                end
                checks++;
                if (rst_if.mode_sel_out !== e.msel) begin
                    errors++;
                    $display("FAIL mode_sel_out t=%0t got %b expected %b", $time, rst_if.mode_sel_out, e.msel);
                end
                checks++;
                if (rst_if.busy_out !== e.busy) begin
                    errors++;
                    $display("FAIL busy_out t=%0t got %b expected %b", $time, rst_if.busy_out, e.busy);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic              mode_r;
        int                dwell;
        logic [NUM_CH-1:0] fcn_r;

        rst_if.scan_mode_en_in = 1'b0;
        rst_if.scan_rst_n_in   = 1'b1;
        rst_if.fcn_rst_n_in    = '1;
        model_async();

        // Reset and release
        repeat_step(3, 1'b0, 1'b0, 1'b1, 4'hF);
        repeat_step(4, 1'b1, 1'b0, 1'b1, 4'hF);

        // Single-channel pulse
        step(1'b1, 1'b0, 1'b1, 4'hB);
        repeat_step(4, 1'b1, 1'b0, 1'b1, 4'hF);

        // Scan entry, scan reset pass-through, functional resets ignored in SCAN
        repeat_step(14, 1'b1, 1'b1, 1'b1, 4'hF);
        step(1'b1, 1'b1, 1'b0, 4'hF);
        step(1'b1, 1'b1, 1'b1, 4'hF);
        step(1'b1, 1'b1, 1'b0, 4'h5);
        step(1'b1, 1'b1, 1'b1, 4'h0);
        step(1'b1, 1'b1, 1'b1, 4'hF);

        // Scan exit
        repeat_step(16, 1'b1, 1'b0, 1'b1, 4'hF);

        // Abort during drain to scan, then abort during drain to functional
        repeat_step(6, 1'b1, 1'b1, 1'b1, 4'hF);
        repeat_step(5, 1'b1, 1'b0, 1'b1, 4'hF);
        repeat_step(16, 1'b1, 1'b1, 1'b1, 4'hF);
        repeat_step(16, 1'b1, 1'b0, 1'b1, 4'hF);

        // Reset while in SCAN with scan mode still requested
        repeat_step(14, 1'b1, 1'b1, 1'b1, 4'hF);
        repeat_step(2, 1'b0, 1'b1, 1'b1, 4'hF);
        repeat_step(14, 1'b1, 1'b1, 1'b1, 4'hF);
        repeat_step(16, 1'b1, 1'b0, 1'b1, 4'hF);

        // Random traffic: mode held for random dwell times, random channel and scan resets, rare block reset
        mode_r = 1'b0;
        dwell  = 0;
        for (int it = 0; it < 3000; it++) begin
            if (dwell == 0) begin
                mode_r = ~mode_r;
                dwell  = $urandom_range(1, 24);
            end
            dwell--;
            fcn_r = '1;
            if ($urandom_range(0, 3) == 0) fcn_r = NUM_CH'($urandom);
            step(($urandom_range(0, 199) != 0), mode_r, 1'($urandom), fcn_r);
        end

        repeat (2) @(posedge clk_in);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
